// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: shared types for the oversampling UART receiver.
// Rev 1.0 - initial release.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        STOP2  = 3'd5
    } uart_rx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_mode_t;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
    } rx_status_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// counter: wrapping up-counter 0..limit with synchronous clear and enable.
// Rev 1.0 - initial release.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == limit) ? '0 : count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// uart_rx_fifo: synchronous show-ahead FIFO with full/empty flags.
// Rev 1.0 - initial release.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en    = pop && !empty;
    // A simultaneous pop frees the slot the write lands in.
    assign wr_en    = push && (!full || rd_en);
    assign out_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// uart_rx_os: oversampling UART receiver with majority voting and receive FIFO.
// Rev 1.0 - initial release.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int OVERSAMPLE    = 16,
    parameter int DIV_WIDTH     = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int LITTLE_ENDIAN = 1
) (
    input  logic                 clk,
    input  logic                 i_reset_n,
    input  logic                 i_rx,
    input  logic [DIV_WIDTH-1:0] i_divisor,
    input  logic [1:0]           i_parity,
    input  logic                 i_two_stop,
    input  logic                 i_clear_err,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int SUB_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'(OVERSAMPLE - 1);
    localparam logic [SUB_W-1:0] SAMP_A   = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SUB_W-1:0] SAMP_B   = SUB_W'(OVERSAMPLE / 2);
    localparam logic [SUB_W-1:0] SAMP_C   = SUB_W'(OVERSAMPLE / 2 + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    logic [1:0]           rst_sync;
    logic                 rst_n;
    logic                 rx_meta, rx_sync, rx_prev;
    uart_rx_state_t       state, next_state;
    logic                 start_edge, busy, tick, decide, bit_val;
    logic                 push, pop, fifo_full, fifo_empty;
    logic [DIV_WIDTH-1:0] div_eff, div_max, tick_cnt;
    logic [SUB_W-1:0]     sub_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [1:0]           samples;
    logic [WIDTH-1:0]     shreg;
    logic                 par_acc, perr, ferr, two_stop, parity_en, overrun;
    parity_mode_t         par_mode;
    rx_status_t           push_status, head_status;
    logic [WIDTH-1:0]     head_data;
    logic [WIDTH+1:0]     fifo_in, fifo_out;

    // Assert asynchronously, release two clocks after i_reset_n rises.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) rst_sync <= 2'b00;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign busy       = (state != IDLE);
    assign start_edge = (state == IDLE) && rx_prev && !rx_sync;
    assign div_eff    = (i_divisor < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : i_divisor;
    assign parity_en  = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);

    counter #(.WIDTH(DIV_WIDTH)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_edge),
        .enable (busy),
        .limit  (div_max),
        .count  (tick_cnt)
    );
    assign tick = busy && (tick_cnt == div_max);

    counter #(.WIDTH(SUB_W)) u_bitphase (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_edge),
        .enable (tick),
        .limit  (SUB_MAX),
        .count  (sub_cnt)
    );
    assign decide  = tick && (sub_cnt == SAMP_C);
    assign bit_val = majority3(samples[0], samples[1], rx_sync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        push       = 1'b0;
        case (state)
            IDLE:   if (start_edge) next_state = START;
            START:  if (decide) next_state = bit_val ? IDLE : DATA;
            DATA:   if (decide && bit_idx == IDX_LAST) next_state = parity_en ? PARITY : STOP;
            PARITY: if (decide) next_state = STOP;
            STOP: begin
                if (decide) begin
                    if (two_stop) begin
                        next_state = STOP2;
                    end else begin
                        push       = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            STOP2: begin
                if (decide) begin
                    push       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples  <= 2'b11;
            shreg    <= '0;
            bit_idx  <= '0;
            par_acc  <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            div_max  <= DIV_WIDTH'(1);
            par_mode <= PAR_NONE;
            two_stop <= 1'b0;
        end else begin
            if (tick && sub_cnt == SAMP_A) samples[0] <= rx_sync;
            if (tick && sub_cnt == SAMP_B) samples[1] <= rx_sync;
            if (start_edge) begin
                bit_idx  <= '0;
                par_acc  <= 1'b0;
                perr     <= 1'b0;
                ferr     <= 1'b0;
                div_max  <= div_eff - DIV_WIDTH'(1);
                par_mode <= parity_mode_t'(i_parity);
                two_stop <= i_two_stop;
            end else if (decide) begin
                case (state)
                    DATA: begin
                        if (LITTLE_ENDIAN != 0) shreg <= {bit_val, shreg[WIDTH-1:1]};
                        else                    shreg <= {shreg[WIDTH-2:0], bit_val};
                        par_acc <= par_acc ^ bit_val;
                        bit_idx <= bit_idx + 1'b1;
                    end
                    PARITY: perr <= (bit_val != (par_acc ^ (par_mode == PAR_ODD)));
                    STOP:   if (!bit_val) ferr <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // The final stop bit's own sample folds into frame_err at push time.
    assign push_status.parity_err = perr;
    assign push_status.frame_err  = ferr | ~bit_val;
    assign fifo_in                = {push_status, shreg};
    assign pop                    = !fifo_empty && i_ready;

    uart_rx_fifo #(.WIDTH(WIDTH + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .in_data  (fifo_in),
        .out_data (fifo_out),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );
    assign head_status = rx_status_t'(fifo_out[WIDTH+1:WIDTH]);
    assign head_data   = fifo_out[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          overrun <= 1'b0;
        else if (push && fifo_full && !pop)  overrun <= 1'b1;
        else if (i_clear_err)                overrun <= 1'b0;
    end

    assign o_valid      = !fifo_empty;
    assign o_data       = o_valid ? head_data : '0;
    assign o_frame_err  = o_valid & head_status.frame_err;
    assign o_parity_err = o_valid & head_status.parity_err;
    assign o_overrun    = overrun;
    assign o_busy       = busy;

endmodule
`default_nettype wire
